// File: rtl/rv32_writeback_arbiter.sv
// rv32_writeback_arbiter: drives the register-file write port from the in-order pipeline
// (priority) and a FIFO of long-latency results, tracking pending long-latency destinations.
module rv32_writeback_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        ll_issue,
    input  logic [4:0]  ll_issue_rd,
    input  logic        ll_valid,
    input  logic [4:0]  ll_rd,
    input  logic [31:0] ll_data,
    output logic        ll_ready,
    input  logic [4:0]  rs [3],
    output logic        rs_pending [3],
    output logic        write,
    output logic [4:0]  rw,
    output logic [31:0] d
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    logic [4:0]    fifo_rd_q   [FIFO_DEPTH];
    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [31:0]   pending_q, pending_d;
    logic          write_q;
    logic [4:0]    rw_q;
    logic [31:0]   d_q;
    logic          pipe_take, pop, push;
    logic [4:0]    head_rd;

    // Ready looks only at registered occupancy, so a full FIFO refuses even while popping.
    assign ll_ready  = (count_q < FULL) && !rst;
    assign pipe_take = pipe_valid && pipe_rd != 5'd0;
    assign pop       = !pipe_take && count_q != '0;
    assign push      = ll_valid && ll_ready;
    assign head_rd   = fifo_rd_q[rd_ptr_q];

    assign write = write_q;
    assign rw    = rw_q;
    assign d     = d_q;

    // Clear first, then set, so a same-cycle reissue of the popped id stays pending.
    always_comb begin
        pending_d = pending_q;
        if (pop) pending_d[head_rd] = 1'b0;
        if (ll_issue) pending_d[ll_issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        for (int i = 0; i < 3; i++) rs_pending[i] = pending_q[rs[i]];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= ll_rd;
            fifo_data_q[wr_ptr_q] <= ll_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            write_q   <= 1'b0;
            rw_q      <= '0;
            d_q       <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_q + (AW+1)'(push) - (AW+1)'(pop);
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            write_q <= pipe_take || (pop && head_rd != 5'd0);
            if (pipe_take) begin
                rw_q <= pipe_rd;
                d_q  <= pipe_data;
            end else if (pop) begin
                rw_q <= head_rd;
                d_q  <= fifo_data_q[rd_ptr_q];
            end
        end
    end
endmodule

// File: tb/tb_rv32_writeback_arbiter.sv
// tb_rv32_writeback_arbiter: directed scenarios plus random traffic against a queue-based
// model of the write-port arbiter and pending scoreboard.
module tb_rv32_writeback_arbiter;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid, ll_issue, ll_valid, ll_ready, write;
    logic [4:0]  pipe_rd, ll_issue_rd, ll_rd, rw;
    logic [31:0] pipe_data, ll_data, d;
    logic [4:0]  rs [3];
    logic        rs_pending [3];

    rv32_writeback_arbiter #(.FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .ll_issue(ll_issue), .ll_issue_rd(ll_issue_rd),
        .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(ll_ready),
        .rs(rs), .rs_pending(rs_pending),
        .write(write), .rw(rw), .d(d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq [$];
    logic [4:0]  outst [$];
    logic [31:0] mpend;
    logic        ew, last_acc;
    logic [4:0]  erw;
    logic [31:0] ed;
    int          n_cmp = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        ent_t e;
        logic rdy;
        last_acc = 1'b0;
        if (rst) begin
            mq.delete();
            outst.delete();
            mpend = '0;
            ew = 1'b0;
            erw = '0;
            ed = '0;
            return;
        end
        rdy = mq.size() < FD;
        if (pipe_valid && pipe_rd != 5'd0) begin
            ew = 1'b1;
            erw = pipe_rd;
            ed = pipe_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            ew = e.rd != 5'd0;
            erw = e.rd;
            ed = e.data;
            mpend[e.rd] = 1'b0;
        end else ew = 1'b0;
        if (ll_valid && rdy) begin
            mq.push_back('{ll_rd, ll_data});
            last_acc = 1'b1;
            if (outst.size() > 0) void'(outst.pop_front());
        end
        if (ll_issue) begin
            outst.push_back(ll_issue_rd);
            mpend[ll_issue_rd] = 1'b1;
        end
        mpend[0] = 1'b0;
    endtask

    task automatic cycle();
        #1;
        for (int i = 0; i < 3; i++) check("rs_pending", 32'(rs_pending[i]), 32'(mpend[rs[i]]));
        @(posedge clk);
        model_edge();
        #1;
        check("write", 32'(write), 32'(ew));
        check("rw", 32'(rw), 32'(erw));
        check("d", d, ed);
        check("ll_ready", 32'(ll_ready), 32'(!rst && mq.size() < FD));
    endtask

    task automatic idle();
        rst = 1'b0;
        pipe_valid = 1'b0;
        ll_issue = 1'b0;
        ll_valid = 1'b0;
    endtask

    task automatic rand_drive();
        int r;
        rst = ($urandom_range(0, 299) == 0);
        pipe_valid = $urandom_range(0, 1) == 1;
        r = $urandom_range(0, 31);
        pipe_rd = mpend[r] ? 5'd0 : 5'(r);
        pipe_data = $urandom;
        r = $urandom_range(0, 31);
        ll_issue = ($urandom_range(0, 2) == 0) && !mpend[r];
        ll_issue_rd = 5'(r);
        if (!(ll_valid && !last_acc && outst.size() > 0 && ll_rd == outst[0])) begin
            ll_valid = outst.size() > 0 && $urandom_range(0, 1) == 1;
            if (outst.size() > 0) ll_rd = outst[0];
            ll_data = $urandom;
        end
        for (int i = 0; i < 3; i++) rs[i] = 5'($urandom_range(0, 31));
    endtask

    initial begin
        int sent, nw;
        idle();
        pipe_rd = '0; pipe_data = '0; ll_issue_rd = '0; ll_rd = '0; ll_data = '0;
        for (int i = 0; i < 3; i++) rs[i] = '0;
        rst = 1'b1;
        @(posedge clk);
        model_edge();
        cycle();
        check("rst_write", 32'(write), 0);
        check("rst_d", d, 0);

        idle();
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
        cycle();
        check("t1_write", 32'(write), 1);
        check("t1_rw", 32'(rw), 5);
        check("t1_d", d, 32'hDEADBEEF);
        pipe_rd = 5'd0; pipe_data = 32'h1;
        cycle();
        check("t1_rd0", 32'(write), 0);

        idle();
        ll_issue = 1'b1; ll_issue_rd = 5'd7;
        cycle();
        idle();
        rs[0] = 5'd7;
        #1 check("t2_pend", 32'(rs_pending[0]), 1);
        ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h1234;
        cycle();
        idle();
        cycle();
        check("t2_write", 32'(write), 1);
        check("t2_rw", 32'(rw), 7);
        check("t2_d", d, 32'h1234);
        #1 check("t2_clr", 32'(rs_pending[0]), 0);

        for (int k = 10; k <= 14; k++) begin
            ll_issue = 1'b1; ll_issue_rd = 5'(k);
            cycle();
        end
        idle();
        for (int i = 0; i < 6; i++) begin
            pipe_valid = 1'b1; pipe_rd = 5'(i + 1); pipe_data = 32'(i);
            ll_valid = 1'b1;
            ll_rd = 5'(i < 4 ? 10 + i : 14);
            ll_data = 32'(100 + (i < 4 ? i : 4));
            if (i == 4) check("t3_full", 32'(ll_ready), 0);
            cycle();
            check("t3_pipe", 32'(rw), 32'(i + 1));
        end
        pipe_valid = 1'b0;
        cycle();
        check("t3_pop10", 32'(rw), 10);
        check("t3_ready", 32'(ll_ready), 1);
        cycle();
        check("t3_pop11", 32'(rw), 11);
        ll_valid = 1'b0;
        cycle();
        check("t3_pop12", 32'(rw), 12);
        cycle();
        check("t3_pop13", 32'(rw), 13);
        cycle();
        check("t3_pop14", 32'(rw), 14);

        idle();
        ll_issue = 1'b1; ll_issue_rd = 5'd9;
        cycle();
        idle();
        ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h99;
        cycle();
        idle();
        ll_issue = 1'b1; ll_issue_rd = 5'd9;
        cycle();
        check("t4_pop9", 32'(rw), 9);
        idle();
        rs[0] = 5'd9;
        #1 check("t4_setwins", 32'(rs_pending[0]), 1);
        ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h98;
        cycle();
        idle();
        cycle();
        check("t4_d98", d, 32'h98);
        ll_issue = 1'b1; ll_issue_rd = 5'd0;
        cycle();
        idle();
        ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'h55;
        cycle();
        idle();
        cycle();
        check("t4_rd0_write", 32'(write), 0);

        for (int i = 0; i < 3 * FD + 1; i++) begin
            ll_issue = 1'b1; ll_issue_rd = 5'(16 + i);
            pipe_valid = (i % 2 == 1); pipe_rd = 5'd1; pipe_data = $urandom;
            cycle();
        end
        idle();
        sent = 0; nw = 0;
        for (int g = 0; g < 200 && sent < 3 * FD + 1; g++) begin
            ll_valid = 1'b1; ll_rd = 5'(16 + sent); ll_data = 32'hA000_0000 + 32'(sent);
            pipe_valid = (g % 2 == 0); pipe_rd = 5'd1; pipe_data = $urandom;
            cycle();
            if (write && rw >= 5'd16 && rw <= 5'd28) nw++;
            if (last_acc) sent++;
        end
        idle();
        repeat (8) begin
            cycle();
            if (write && rw >= 5'd16 && rw <= 5'd28) nw++;
        end
        check("t5_sent", 32'(sent), 3 * FD + 1);
        check("t5_writes", 32'(nw), 3 * FD + 1);

        for (int k = 0; k < 3; k++) begin
            ll_issue = 1'b1; ll_issue_rd = 5'(21 + k);
            cycle();
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'(k);
            ll_valid = 1'b1; ll_rd = 5'(21 + k); ll_data = 32'(500 + k);
            cycle();
        end
        idle();
        rst = 1'b1;
        cycle();
        check("t6_write", 32'(write), 0);
        for (int i = 0; i < 3; i++) rs[i] = 5'(21 + i);
        #1;
        for (int i = 0; i < 3; i++) check("t6_pend", 32'(rs_pending[i]), 0);
        rst = 1'b0;
        cycle();
        check("t6_ready", 32'(ll_ready), 1);
        repeat (4) begin
            cycle();
            check("t6_stale", 32'(write), 0);
        end

        idle();
        last_acc = 1'b0;
        repeat (3000) begin
            rand_drive();
            cycle();
        end
        idle();
        repeat (10) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rv32_writeback_arbiter.md
Name: rv32_writeback_arbiter

Overview:
Drives the single write port of the core register file (write, rw, d), which captures on negedge clk.
- Merges two result sources:
  - the in-order pipeline result, which always wins and has no backpressure;
  - a long-latency unit result (mul/div/load), buffered in a small FIFO with valid/ready.
- Keeps a 32-bit pending-register scoreboard for long-latency destinations, queried by decode's three read-port register ids.

Parameters:
FIFO_DEPTH, 4, long-latency result FIFO entries; power of two, >=2

Ports:
clk  in  1  core clock
rst  in  1  reset: synchronous, active-high
pipe_valid  in  1  in-order pipeline result present this cycle
pipe_rd  in  5 (rv_reg_id_t)  pipeline destination register
pipe_data  in  32 (rv32_word)  pipeline result
ll_issue  in  1  long-latency op issued this cycle
ll_issue_rd  in  5 (rv_reg_id_t)  destination of the issued long-latency op
ll_valid  in  1  long-latency result offered
ll_rd  in  5 (rv_reg_id_t)  long-latency result destination
ll_data  in  32 (rv32_word)  long-latency result
ll_ready  out  1  FIFO accepts the offered result
rs[3]  in  3x5 (rv_reg_id_t)  decode source registers
rs_pending[3]  out  3x1  matching source register has an outstanding long-latency write
write  out  1  register file write enable
rw  out  5 (rv_reg_id_t)  register file write id
d  out  32 (rv32_word)  register file write data

Behaviour:
Output register
- write/rw/d are registered.
- Reset values: write=0, rw=0, d=0.
- At most one write per cycle.

Selection at each posedge
- Pipeline slot: pipe_valid=1 and pipe_rd!=0 loads {1, pipe_rd, pipe_data}.
- FIFO slot: otherwise, if the FIFO is non-empty, pop the head and load {head_rd!=0, head_rd, head_data}.
- Idle: otherwise write=0, with rw/d holding their previous values.
- Latency:
  - pipeline result reaches the write port 1 cycle after presentation;
  - long-latency result is visible 2 cycles after acceptance when the pipeline is idle.
- pipe_valid with pipe_rd=0 is discarded and does not block a FIFO pop that cycle.

FIFO
- ll_ready = (count < FIFO_DEPTH) and !rst. It is purely registered-state based, with no same-cycle pop bypass, so a full FIFO deasserts ready even if a pop happens that cycle.
- Push when ll_valid && ll_ready.
- Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop: count unchanged.
- Order is preserved.
- An entry with rd=0 is accepted, then popped with write=0 in its slot.

Scoreboard: pending[31:0], reset all 0
- Set: ll_issue && ll_issue_rd!=0 sets pending[ll_issue_rd].
- Clear: a FIFO pop with head_rd!=0 clears pending[head_rd] on the same edge the output register loads that entry.
- Set and clear on the same id in one cycle: set wins.
- pending[0] is hard 0.
- rs_pending[i] = pending[rs[i]], combinational, for i=0..2.
- Clearing at load is sufficient for hazard freedom because the register file captures on the following negedge, before decode's next read.

Protocol rules (bench asserts; RTL is not required to handle violations)
- No ll_issue to an rd whose pending bit is already set.
- No pipe_valid write to a pending rd.
- ll_rd/ll_data must be stable while ll_valid && !ll_ready.

Reset mid-operation
- FIFO flushed (count=0) and pending cleared.
- write=0 on the cycle after the reset edge.
- In-flight results are lost; the upstream units are reset by the same rst.

Test Plan:
1. Pipeline only: pipe_valid=1, pipe_rd=5, pipe_data=0xDEADBEEF at cycle N -> write=1, rw=5, d=0xDEADBEEF after edge N+1; pipe_rd=0 -> write stays 0.
2. Long-latency path:
   - ll_issue rd=7 -> rs[0]=7 gives rs_pending[0]=1 next cycle;
   - ll_valid rd=7, data=0x1234 with the pipeline idle -> write rw=7, d=0x1234 two edges after acceptance;
   - rs_pending[0] returns to 0 on that load edge.
3. Contention:
   - pipeline busy for 6 cycles (rd=1..6) while 4 long-latency results (rd=10..13) arrive;
   - FIFO fills, and ll_ready=0 on a 5th offer;
   - after the pipeline goes idle, writes 10,11,12,13 follow in order on consecutive cycles, and ll_ready reasserts.
4. Same-cycle set/clear: pop of rd=9 coincides with ll_issue rd=9 -> pending[9] remains 1; rd=0 issue/result -> no pending bit set and write=0 in the pop slot.
5. Wrap-around: stream 3*FIFO_DEPTH+1 long-latency results with alternating pipeline traffic -> every result written exactly once, in order, with data intact.
6. Reset mid-operation: FIFO holding 3 entries with pending bits set, assert rst for 1 cycle -> write=0 and all rs_pending=0; after release, ll_ready=1 with count=0 and no stale writes appear.
